// File: rtl/id_pkg.sv
// Shared decode definitions for the 16-bit-ISA instruction-decode stage:
// opcode values, instruction field positions and the decoded control bundle.
package id_pkg;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS_HI  = 7;
  localparam int RS_LO  = 4;
  localparam int RT_HI  = 3;
  localparam int RT_LO  = 0;
  localparam int BRC_HI = 11;
  localparam int BRC_LO = 9;

  localparam logic [3:0] OP_ALU_LAST = 4'h7;
  localparam logic [3:0] OP_LW       = 4'h8;
  localparam logic [3:0] OP_SW       = 4'h9;
  localparam logic [3:0] OP_LIL      = 4'hA;
  localparam logic [3:0] OP_LIH      = 4'hB;
  localparam logic [3:0] OP_BR       = 4'hC;
  localparam logic [3:0] OP_JAL      = 4'hD;
  localparam logic [3:0] OP_JR       = 4'hE;
  localparam logic [3:0] OP_HLT      = 4'hF;

  localparam logic [3:0] LINK_REG = 4'd15;

  typedef enum logic [1:0] {
    IMM_NONE,
    IMM_4,
    IMM_8,
    IMM_9
  } imm_sel_e;

  // useA/useB: the instruction consumes read port A/B (drives operands and hazard check)
  typedef struct packed {
    logic       we;
    logic       memRd;
    logic       memWr;
    logic       br;
    logic       jump;
    logic       halt;
    logic       useA;
    logic       useB;
    logic       link;
    logic [3:0] aluOp;
    logic [3:0] dst;
    logic [2:0] brCond;
    imm_sel_e   immSel;
  } ctrl_t;

endpackage

// File: rtl/id_regfile.sv
// 16-entry register file: two combinational read ports, one write port.
// Optional hard-wired zero R0 and same-cycle write-back forwarding.
module id_regfile
  import id_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter bit ZERO_R0   = 1'b1,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        raddrA,
  input  logic [3:0]        raddrB,
  output logic [DATA_W-1:0] rdataA,
  output logic [DATA_W-1:0] rdataB,
  input  logic              we,
  input  logic [3:0]        waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [16];
  logic              wrEn;

  assign wrEn = we && !(ZERO_R0 && (waddr == 4'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (wrEn) begin
      mem[waddr] <= wdata;
    end
  end

  function automatic logic [DATA_W-1:0] readPort(input logic [3:0] a);
    if (ZERO_R0 && (a == 4'd0)) return '0;
    if (WB_BYPASS && we && (waddr == a)) return wdata;
    return mem[a];
  endfunction

  always_comb begin
    rdataA = readPort(raddrA);
    rdataB = readPort(raddrB);
  end

endmodule

// File: rtl/id_stage_p.sv
// Decode stage: decodes one instruction per cycle into a registered ID/EX stage,
// with load-use interlock, flush and a sticky halt that refuses input until reset.
module id_stage_p
  import id_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter bit ZERO_R0   = 1'b1,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic              in_ready,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_p0,
  output logic [DATA_W-1:0] out_p1,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_link,
  output logic [3:0]        out_dst,
  output logic              out_we,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic              out_br,
  output logic              out_jump,
  output logic [3:0]        out_alu_op,
  output logic [2:0]        out_br_cond,
  output logic              halted
);

  logic [3:0] op, rd, rs, rt;
  assign op = in_instr[OP_HI:OP_LO];
  assign rd = in_instr[RD_HI:RD_LO];
  assign rs = in_instr[RS_HI:RS_LO];
  assign rt = in_instr[RT_HI:RT_LO];

  ctrl_t ctrl;

  always_comb begin
    ctrl        = '0;
    ctrl.immSel = IMM_NONE;
    if (op <= OP_ALU_LAST) begin
      ctrl.we    = 1'b1;
      ctrl.useA  = 1'b1;
      ctrl.useB  = 1'b1;
      ctrl.dst   = rd;
      ctrl.aluOp = op;
    end else begin
      case (op)
        OP_LW: begin
          ctrl.we     = 1'b1;
          ctrl.memRd  = 1'b1;
          ctrl.useA   = 1'b1;
          ctrl.dst    = rd;
          ctrl.immSel = IMM_4;
        end
        OP_SW: begin
          ctrl.memWr  = 1'b1;
          ctrl.useA   = 1'b1;
          ctrl.useB   = 1'b1;
          ctrl.immSel = IMM_4;
        end
        OP_LIL, OP_LIH: begin
          ctrl.we     = 1'b1;
          ctrl.useA   = 1'b1;
          ctrl.dst    = rd;
          ctrl.aluOp  = op;
          ctrl.immSel = IMM_8;
        end
        OP_BR: begin
          ctrl.br     = 1'b1;
          ctrl.brCond = in_instr[BRC_HI:BRC_LO];
          ctrl.immSel = IMM_9;
        end
        OP_JAL: begin
          ctrl.jump = 1'b1;
          ctrl.we   = 1'b1;
          ctrl.dst  = LINK_REG;
          ctrl.link = 1'b1;
        end
        OP_JR: begin
          ctrl.jump = 1'b1;
          ctrl.useA = 1'b1;
        end
        default: ctrl.halt = 1'b1;
      endcase
    end
  end

  // Load-immediate reads its own destination; store reads rd as the data operand
  logic [3:0] addrA, addrB;
  assign addrA = (op == OP_LIL || op == OP_LIH) ? rd : rs;
  assign addrB = (op == OP_SW) ? rd : rt;

  logic [DATA_W-1:0] rdataA, rdataB;

  id_regfile #(
    .DATA_W   (DATA_W),
    .ZERO_R0  (ZERO_R0),
    .WB_BYPASS(WB_BYPASS)
  ) uRegfile (
    .clk   (clk),
    .rst   (rst),
    .raddrA(addrA),
    .raddrB(addrB),
    .rdataA(rdataA),
    .rdataB(rdataB),
    .we    (wb_we),
    .waddr (wb_addr),
    .wdata (wb_data)
  );

  logic [DATA_W-1:0] immVal, p0Val, p1Val, linkVal;

  always_comb begin
    immVal = '0;
    case (ctrl.immSel)
      IMM_4:   immVal = {{(DATA_W-4){in_instr[3]}}, in_instr[3:0]};
      IMM_8:   immVal = {{(DATA_W-8){in_instr[7]}}, in_instr[7:0]};
      IMM_9:   immVal = {{(DATA_W-9){in_instr[8]}}, in_instr[8:0]};
      default: immVal = '0;
    endcase
  end

  assign p0Val   = ctrl.useA ? rdataA : '0;
  assign p1Val   = ctrl.useB ? rdataB : '0;
  assign linkVal = ctrl.link ? in_pc + DATA_W'(1) : '0;

  logic hazard, advance, accept;

  assign hazard  = out_valid && out_mem_rd &&
                   ((ctrl.useA && (out_dst == addrA)) || (ctrl.useB && (out_dst == addrB)));
  assign advance = !out_valid || out_ready;
  assign in_ready = (advance && !hazard && !halted) || flush;
  assign accept  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_p0      <= '0;
      out_p1      <= '0;
      out_imm     <= '0;
      out_link    <= '0;
      out_dst     <= '0;
      out_we      <= 1'b0;
      out_mem_rd  <= 1'b0;
      out_mem_wr  <= 1'b0;
      out_br      <= 1'b0;
      out_jump    <= 1'b0;
      out_alu_op  <= '0;
      out_br_cond <= '0;
      halted      <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (advance) begin
        // HLT is consumed but travels on as a bubble
        out_valid <= accept && !ctrl.halt;
        if (accept) begin
          out_p0      <= p0Val;
          out_p1      <= p1Val;
          out_imm     <= immVal;
          out_link    <= linkVal;
          out_dst     <= ctrl.dst;
          out_we      <= ctrl.we;
          out_mem_rd  <= ctrl.memRd;
          out_mem_wr  <= ctrl.memWr;
          out_br      <= ctrl.br;
          out_jump    <= ctrl.jump;
          out_alu_op  <= ctrl.aluOp;
          out_br_cond <= ctrl.brCond;
        end
      end
      if (accept && ctrl.halt) halted <= 1'b1;
    end
  end

endmodule
